// File: rtl/vector_scale_backward_pkg.sv
// Shared definitions for vector_scale_backward: fp32 field layout, special
// encodings and the control FSM state type.
package vector_scale_backward_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int BIAS     = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;
  localparam logic [31:0] FP32_ZERO = 32'h00000000;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

endpackage

// File: rtl/vector_scale_backward_fp32_mul_pipe.sv
// fp32_mul_pipe: IEEE-754 single-precision multiplier (round-to-nearest-even)
// followed by MUL_LAT register stages. A valid tag rides alongside each product.
//   clk, rst_n : clock, async active-low reset (clears the valid tags)
//   a, b       : fp32 operands, sampled in the issue cycle
//   in_vld     : operand pair is valid
//   p, out_vld : product and its tag, MUL_LAT cycles after issue
// Build option: define VSCALE_FTZ_EN to flush subnormal operands and results
// (magnitude below 2^-126 after rounding) to signed zero.
module fp32_mul_pipe
  import vector_scale_backward_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_vld,
  output logic [31:0] p,
  output logic        out_vld
);

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic             s;
    logic [EXP_W-1:0] ex, ey, exe, eye, expf;
    logic [MAN_W-1:0] fx, fy;
    logic [23:0]      mx, my;
    logic             x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, rnd;
    logic [47:0]      prod, norm;
    logic [72:0]      w;
    logic [30:0]      mag;
    int               msb, e, sh;
    s     = x[SIGN_BIT] ^ y[SIGN_BIT];
    ex    = x[MAN_W +: EXP_W];
    ey    = y[MAN_W +: EXP_W];
    fx    = x[MAN_W-1:0];
    fy    = y[MAN_W-1:0];
    x_nan = (ex == '1) && (fx != '0);
    y_nan = (ey == '1) && (fy != '0);
    x_inf = (ex == '1) && (fx == '0);
    y_inf = (ey == '1) && (fy == '0);
    mx    = {ex != '0, fx};
    my    = {ey != '0, fy};
`ifdef VSCALE_FTZ_EN
    if (ex == '0) mx = '0;
    if (ey == '0) my = '0;
`endif
    x_zero = (mx == '0);
    y_zero = (my == '0);
    // Subnormals carry the exponent of the smallest normal.
    exe  = (ex == '0) ? 8'd1 : ex;
    eye  = (ey == '0) ? 8'd1 : ey;
    prod = 48'(mx) * 48'(my);
    msb  = 0;
    for (int i = 0; i < 48; i++) if (prod[i]) msb = i;
    norm = prod << (47 - msb);
    // Biased exponent of the normalised product (leading one at norm[47]).
    e    = int'(exe) + int'(eye) - BIAS + 1 - (47 - msb);
    // Normal results keep norm[47:24]; subnormal results shift further right.
    sh   = (e >= 1) ? 24 : 25 - e;
    if (sh > 49) sh = 49;
    w    = 73'({norm, 50'b0} >> sh);
    rnd  = w[49] && ((|w[48:0]) || w[50]);
    expf = (e >= 1) ? e[7:0] : 8'd0;
    // A rounding carry out of the mantissa bumps the exponent field, which
    // also turns a max-finite round-up into the inf encoding.
    mag  = {expf, w[72:50]} + {30'd0, rnd};
    if (x_nan || y_nan)            return FP32_QNAN;
    else if (x_inf || y_inf)       return (x_zero || y_zero) ? FP32_QNAN : (FP32_PINF | {s, 31'd0});
    else if (x_zero || y_zero)     return FP32_ZERO | {s, 31'd0};
    else if (e >= 255)             return FP32_PINF | {s, 31'd0};
`ifdef VSCALE_FTZ_EN
    else if (mag[30:23] == '0)     return FP32_ZERO | {s, 31'd0};
`endif
    else                           return {s, mag};
  endfunction

  logic [MUL_LAT-1:0]       vld_pipe;
  logic [MUL_LAT-1:0][31:0] p_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      p_pipe   <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      p_pipe[0]   <= fmul(a, b);
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        p_pipe[i]   <= p_pipe[i-1];
      end
    end
  end

  assign p       = p_pipe[MUL_LAT-1];
  assign out_vld = vld_pipe[MUL_LAT-1];

endmodule

// File: rtl/vector_scale_backward.sv
// vector_scale_backward: computes scalar * vec_in element-wise (fp32) through
// one shared pipelined multiplier, one element issued per cycle.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : input handshake for scalar and vec_in
//   scalar, vec_in       : fp32 g and VLEN packed fp32 elements (elem i at [32i+31:32i])
//   out_valid/out_ready  : output handshake; vec_out held stable while waiting
//   vec_out              : fp32 g*W, same packing as vec_in
// Build option: VSCALE_FTZ_EN selects flush-to-zero in the multiplier.
module vector_scale_backward
  import vector_scale_backward_pkg::*;
#(
  parameter int VLEN    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          scalar,
  input  logic [32*VLEN-1:0]   vec_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*VLEN-1:0]   vec_out
);

  localparam int IDX_W = $clog2(VLEN + 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         issue_idx_q, issue_idx_d, write_idx_q, write_idx_d;
  logic [31:0]              scalar_q;
  logic [VLEN-1:0][31:0]    vec_q, res_q;
  logic [31:0]              op_b, mul_p;
  logic                     mul_vld, last_issue, last_write;

  always_comb begin
    op_b = '0;
    for (int i = 0; i < VLEN; i++)
      if (issue_idx_q == IDX_W'(i)) op_b = vec_q[i];
  end

  assign last_issue = (issue_idx_q == IDX_W'(VLEN-1));
  // The last product lands at the end of this cycle, so DONE starts exactly
  // when write_idx becomes VLEN.
  assign last_write = mul_vld && (write_idx_q == IDX_W'(VLEN-1));

  fp32_mul_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (scalar_q),
    .b       (op_b),
    .in_vld  (state_q == RUN),
    .p       (mul_p),
    .out_vld (mul_vld)
  );

  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    write_idx_d = mul_vld ? write_idx_q + 1'b1 : write_idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d     = RUN;
        issue_idx_d = '0;
        write_idx_d = '0;
      end
      RUN: begin
        issue_idx_d = issue_idx_q + 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: if (last_write) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      write_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      write_idx_q <= write_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scalar_q <= '0;
      vec_q    <= '0;
    end else if (state_q == IDLE && in_valid) begin
      scalar_q <= scalar;
      vec_q    <= vec_in;
    end
  end

  // Tagged products only arrive during RUN/DRAIN, so the result is frozen in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (mul_vld) begin
      for (int i = 0; i < VLEN; i++)
        if (write_idx_q == IDX_W'(i)) res_q[i] <= mul_p;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign vec_out   = res_q;

endmodule

// File: tb/tb_vector_scale_backward.sv
module tb_vector_scale_backward;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // instance A: VLEN=2, MUL_LAT=2
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_scalar;
  logic [63:0] a_vec, a_vec_out;
  // instance B: VLEN=1, MUL_LAT=1
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_scalar, b_vec, b_vec_out;

  vector_scale_backward #(.VLEN(2), .MUL_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .scalar(a_scalar), .vec_in(a_vec), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .vec_out(a_vec_out));

  vector_scale_backward #(.VLEN(1), .MUL_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .scalar(b_scalar), .vec_in(b_vec), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .vec_out(b_vec_out));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: exact real product, then RNE to fp32
  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction
  function automatic bit is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 0);
  endfunction
  function automatic bit is_zero(input logic [31:0] v);
`ifdef VSCALE_FTZ_EN
    return v[30:23] == 8'h00;
`else
    return v[30:0] == 31'h0;
`endif
  endfunction

  function automatic real fp_mag(input logic [31:0] v);
    int e, f;
    e = int'(v[30:23]);
    f = int'(v[22:0]);
    if (e == 0) begin
`ifdef VSCALE_FTZ_EN
      return 0.0;
`else
      return $itor(f) * pow2(-149);
`endif
    end
    return ($itor(f) + 8388608.0) * pow2(e - 150);
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    real  x, y, sc, fr;
    int   k, q, n, field;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
    if (is_inf(a) || is_inf(b))
      return (is_zero(a) || is_zero(b)) ? 32'h7FC00000 : {s, 31'h7F800000};
    x = fp_mag(a) * fp_mag(b);
    if (x == 0.0) return {s, 31'h0};
    y = x; k = 0;
    while (y >= 2.0) begin y = y / 2.0; k++; end
    while (y < 1.0)  begin y = y * 2.0; k--; end
    if (k < -126) k = -126;
    q  = k - 23;
    sc = x / pow2(q);
    n  = $rtoi(sc);
    fr = sc - $itor(n);
    if (fr > 0.5 || (fr == 0.5 && n[0])) n++;
    if (n == (1 << 24)) begin n = n / 2; q++; end
    if (n < (1 << 23)) begin
`ifdef VSCALE_FTZ_EN
      return {s, 31'h0};
`else
      return {s, 8'h00, 23'(n)};
`endif
    end
    field = q + 23 + 127;
    if (field >= 255) return {s, 31'h7F800000};
    return {s, 8'(field), 23'(n)};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) r[22:0] = '0; end
      2: r[30:0] = '0;
      3: r[30:23] = 8'($urandom_range(1, 4));
      4: r[30:23] = 8'($urandom_range(55, 72));
      5: r[30:23] = 8'($urandom_range(190, 254));
      6: r[30:23] = 8'($urandom_range(120, 134));
      default: ;
    endcase
    return r;
  endfunction

  // Present a job to A, then wait for out_valid and check the latency.
  task automatic a_job(input logic [31:0] s, input logic [63:0] v);
    int lat;
    a_scalar = s; a_vec = v; a_in_valid = 1'b1;
    chk1("a_in_ready_idle", a_in_ready, 1'b1);
    tick();
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 40) begin tick(); lat++; end
    chk("a_latency", 32'(lat), 32'd5);
  endtask

  task automatic a_model(input logic [31:0] s, input logic [63:0] v);
    for (int i = 0; i < 2; i++)
      chk($sformatf("a_model_e%0d s=%h w=%h", i, s, v[32*i +: 32]),
          a_vec_out[32*i +: 32], ref_mul(s, v[32*i +: 32]));
  endtask

  task automatic a_done();
    tick();
    chk1("a_in_ready_after", a_in_ready, 1'b1);
    chk1("a_out_valid_after", a_out_valid, 1'b0);
  endtask

  logic [31:0] rs, snap0, snap1;
  logic [63:0] rv, snap;
  logic [31:0] exp_q[$];
  int          nbad, nout, last_c;
  bit          hs;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 1; a_scalar = 0; a_vec = 0;
    b_in_valid = 0; b_out_ready = 1; b_scalar = 0; b_vec = 0;
    #12;
    chk1("rst_in_ready", a_in_ready, 1'b1);
    chk1("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_vec_out_lo", a_vec_out[31:0], 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // basic: 2.0 * {-3.0, 1.0}
    a_job(32'h40000000, {32'h3F800000, 32'hC0400000});
    chk("basic_e0", a_vec_out[31:0], 32'hC0C00000);
    chk("basic_e1", a_vec_out[63:32], 32'h40000000);
    a_done();

    // special: 0 * inf -> qNaN, 0 * -1 -> -0
    a_job(32'h00000000, {32'hBF800000, 32'h7F800000});
    chk("special_e0", a_vec_out[31:0], 32'h7FC00000);
    chk("special_e1", a_vec_out[63:32], 32'h80000000);
    a_done();

    // subnormal results; 0.5 * 2^-149 is an exact tie rounding to even zero
    a_job(32'h3F000000, {32'h00000001, 32'h00800000});
`ifdef VSCALE_FTZ_EN
    chk("subn_e0", a_vec_out[31:0], 32'h00000000);
`else
    chk("subn_e0", a_vec_out[31:0], 32'h00400000);
`endif
    chk("subn_e1", a_vec_out[63:32], 32'h00000000);
    a_done();

    // overflow to signed inf
    a_job(32'h7F000000, {32'hFF7FFFFF, 32'h7F000000});
    chk("ovf_e0", a_vec_out[31:0], 32'h7F800000);
    chk("ovf_e1", a_vec_out[63:32], 32'hFF800000);
    a_done();

    // backpressure: hold out_ready low 10 cycles, pulse in_valid meanwhile
    a_out_ready = 1'b0;
    rs = rnd_fp(); rv = {rnd_fp(), rnd_fp()};
    a_job(rs, rv);
    a_model(rs, rv);
    snap = a_vec_out;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin a_in_valid = 1'b1; a_scalar = 32'h40400000; a_vec = {32'h3F800000, 32'h3F800000}; end
      tick();
      a_in_valid = 1'b0;
      chk1("bp_out_valid", a_out_valid, 1'b1);
      chk("bp_vec_stable_lo", a_vec_out[31:0], snap[31:0]);
      chk("bp_vec_stable_hi", a_vec_out[63:32], snap[63:32]);
      chk1("bp_in_ready", a_in_ready, 1'b0);
    end
    a_out_ready = 1'b1;
    a_done();
    tick();
    chk1("bp_pulse_ignored", a_out_valid, 1'b0);

    // reset two cycles after the input handshake
    a_scalar = 32'h40000000; a_vec = {32'h40400000, 32'h3FC00000}; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", a_out_valid, 1'b0);
    chk("midrst_vec_lo", a_vec_out[31:0], 32'h0);
    chk("midrst_vec_hi", a_vec_out[63:32], 32'h0);
    chk1("midrst_in_ready", a_in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    nbad = 0;
    for (int k = 0; k < 12; k++) begin
      if (a_out_valid) nbad++;
      tick();
    end
    chk("midrst_no_stale_out", 32'(nbad), 32'd0);
    a_job(32'hC0000000, {32'h3E800000, 32'h41200000});
    chk("post_rst_e0", a_vec_out[31:0], 32'hC1A00000);
    chk("post_rst_e1", a_vec_out[63:32], 32'hBF000000);
    a_done();

    // randomized jobs against the reference model
    for (int j = 0; j < 30; j++) begin
      rs = rnd_fp(); rv = {rnd_fp(), rnd_fp()};
      a_job(rs, rv);
      a_model(rs, rv);
      a_done();
    end

    // VLEN=1, MUL_LAT=1: back-to-back with in_valid held high
    b_scalar = rnd_fp(); b_vec = rnd_fp(); b_in_valid = 1'b1;
    nout = 0; last_c = 0;
    for (int c = 0; c < 80 && nout < 8; c++) begin
      hs = b_in_ready;
      if (hs) exp_q.push_back(ref_mul(b_scalar, b_vec));
      if (b_out_valid) begin
        if (exp_q.size() == 0) chk("b_unexpected_out", b_vec_out, 32'hxxxxxxxx);
        else chk("b_model", b_vec_out, exp_q.pop_front());
        if (nout > 0) chk("b_spacing", 32'(c - last_c), 32'd4);
        last_c = c;
        nout++;
      end
      tick();
      if (hs) begin b_scalar = rnd_fp(); b_vec = rnd_fp(); end
    end
    b_in_valid = 1'b0;
    chk("b_out_count", 32'(nout), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
